// File: rtl/commit_perf_monitor_if.sv
// -----------------------------------------------------------------------------
// commit_perf_monitor_if
// Commit-stream bundle observed by commit_perf_monitor. One bit per lane,
// lane index t*COMMIT_WIDTH+l (lane 0 of each thread is the oldest).
//   thread_active      threads that must commit a halt before the run is done
//   commit_valid       lane commits this cycle
//   commit_halt        committed lane is a halt
//   commit_branch      committed lane is a branch
//   commit_br_correct  branch was correctly predicted
//   error_stop         pipeline reported a non-halt error
// master: the pipeline side driving the stream; slave: the monitor.
// -----------------------------------------------------------------------------
interface commit_perf_monitor_if #(
   parameter int NUM_THREADS  = 2,
   parameter int COMMIT_WIDTH = 2
);
   logic [NUM_THREADS-1:0]              thread_active;
   logic [NUM_THREADS*COMMIT_WIDTH-1:0] commit_valid;
   logic [NUM_THREADS*COMMIT_WIDTH-1:0] commit_halt;
   logic [NUM_THREADS*COMMIT_WIDTH-1:0] commit_branch;
   logic [NUM_THREADS*COMMIT_WIDTH-1:0] commit_br_correct;
   logic                                error_stop;

   modport master (
      output thread_active,
      output commit_valid,
      output commit_halt,
      output commit_branch,
      output commit_br_correct,
      output error_stop
   );

   modport slave (
      input  thread_active,
      input  commit_valid,
      input  commit_halt,
      input  commit_branch,
      input  commit_br_correct,
      input  error_stop
   );
endinterface

// File: rtl/commit_perf_monitor.sv
// -----------------------------------------------------------------------------
// commit_perf_monitor
// Counts cycles, committed instructions (per thread and total), branches and
// correctly predicted branches from the ROB commit stream of an SMT pipeline.
// The run ends (DONE) when every active thread has committed a halt or the
// pipeline raises error_stop; a no-commit watchdog moves to HANG. Counters
// freeze outside RUN and are read through rd_sel/rd_data.
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   clear          synchronous clear of counters/flags, returns to RUN
//   commit         commit-stream bundle (slave modport)
//   rd_sel         0=cycles 1=total 2=branches 3=correct 4+t=thread t
//   rd_data        selected counter, 0 for out-of-range selects
//   state          0=RUN 1=DONE 2=HANG
//   thread_halted  sticky per-thread halt seen
//   errored        DONE was entered through error_stop
// -----------------------------------------------------------------------------
module commit_perf_monitor #(
   parameter int NUM_THREADS  = 2,
   parameter int COMMIT_WIDTH = 2,
   parameter int CNT_W        = 32,
   parameter int TIMEOUT      = 500000,
   parameter int SEL_W        = $clog2(4 + NUM_THREADS)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    clear,
   commit_perf_monitor_if.slave    commit,
   input  logic [SEL_W-1:0]        rd_sel,
   output logic [CNT_W-1:0]        rd_data,
   output logic [1:0]              state,
   output logic [NUM_THREADS-1:0]  thread_halted,
   output logic                    errored
);

   localparam int LANES  = NUM_THREADS * COMMIT_WIDTH;
   localparam int INC_W  = $clog2(LANES + 1);
   localparam int SUM_W  = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
   // The idle counter only has to reach TIMEOUT-1.
   localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      DONE = 2'd1,
      HANG = 2'd2
   } state_e;

   // Saturating counter add: never wraps past all-ones.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                input logic [INC_W-1:0] inc);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(cnt) + SUM_W'(inc);
      if (sum > SUM_W'(CNT_MAX)) begin
         sat_add = CNT_MAX;
      end else begin
         sat_add = sum[CNT_W-1:0];
      end
   endfunction

   state_e                  state_r;
   state_e                  state_next_s;
   logic [CNT_W-1:0]        cycles_r;
   logic [CNT_W-1:0]        total_r;
   logic [CNT_W-1:0]        branches_r;
   logic [CNT_W-1:0]        correct_r;
   logic [CNT_W-1:0]        thread_cnt_r [NUM_THREADS];
   logic [NUM_THREADS-1:0]  thread_halted_r;
   logic                    errored_r;
   logic [IDLE_W-1:0]       idle_r;

   logic [LANES-1:0]        counted_s;
   logic [NUM_THREADS-1:0]  halt_now_s;
   logic [INC_W-1:0]        thread_inc_s [NUM_THREADS];
   logic [INC_W-1:0]        total_inc_s;
   logic [INC_W-1:0]        br_inc_s;
   logic [INC_W-1:0]        corr_inc_s;
   logic                    activity_s;
   logic                    all_halted_s;
   logic [CNT_W-1:0]        thread_pick_s;

   // Lane qualification: lanes younger than a halt in the same thread are
   // dropped; a halt itself is not counted, and an already halted thread
   // contributes no counted lanes.
   always_comb begin : lane_qual
      logic blocked;
      counted_s  = '0;
      halt_now_s = '0;
      blocked    = 1'b0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         blocked = 1'b0;
         for (int l = 0; l < COMMIT_WIDTH; l++) begin
            if (commit.commit_valid[t*COMMIT_WIDTH+l] && !blocked) begin
               if (commit.commit_halt[t*COMMIT_WIDTH+l]) begin
                  halt_now_s[t] = 1'b1;
                  blocked       = 1'b1;
               end else if (!thread_halted_r[t]) begin
                  counted_s[t*COMMIT_WIDTH+l] = 1'b1;
               end else begin
                  counted_s[t*COMMIT_WIDTH+l] = 1'b0;
               end
            end else begin
               counted_s[t*COMMIT_WIDTH+l] = 1'b0;
            end
         end
      end
   end

   // Per-cycle popcounts over counted lanes.
   always_comb begin
      total_inc_s = '0;
      br_inc_s    = '0;
      corr_inc_s  = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         thread_inc_s[t] = '0;
         for (int l = 0; l < COMMIT_WIDTH; l++) begin
            thread_inc_s[t] = thread_inc_s[t] + INC_W'(counted_s[t*COMMIT_WIDTH+l]);
            total_inc_s     = total_inc_s + INC_W'(counted_s[t*COMMIT_WIDTH+l]);
            br_inc_s        = br_inc_s + INC_W'(counted_s[t*COMMIT_WIDTH+l]
                                                & commit.commit_branch[t*COMMIT_WIDTH+l]);
            corr_inc_s      = corr_inc_s + INC_W'(counted_s[t*COMMIT_WIDTH+l]
                                                  & commit.commit_branch[t*COMMIT_WIDTH+l]
                                                  & commit.commit_br_correct[t*COMMIT_WIDTH+l]);
         end
      end
   end

   // Run-completion and watchdog qualifiers; halts of this cycle count toward done.
   always_comb begin
      activity_s   = (|counted_s) | (|halt_now_s);
      all_halted_s = (commit.thread_active != '0) &&
                     (((thread_halted_r | halt_now_s) & commit.thread_active)
                      == commit.thread_active);
   end

   // Next-state logic: clear wins, then error, halt completion, watchdog.
   always_comb begin
      state_next_s = state_r;
      if (clear) begin
         state_next_s = RUN;
      end else begin
         case (state_r)
            RUN: begin
               if (commit.error_stop) begin
                  state_next_s = DONE;
               end else if (all_halted_s) begin
                  state_next_s = DONE;
               end else if ((idle_r == IDLE_LAST) && !activity_s) begin
                  state_next_s = HANG;
               end else begin
                  state_next_s = RUN;
               end
            end
            DONE:    state_next_s = DONE;
            HANG:    state_next_s = HANG;
            default: state_next_s = RUN;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= RUN;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Counters, sticky flags and idle counter; updated only while in RUN.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cycles_r        <= '0;
         total_r         <= '0;
         branches_r      <= '0;
         correct_r       <= '0;
         thread_halted_r <= '0;
         errored_r       <= 1'b0;
         idle_r          <= '0;
         for (int t = 0; t < NUM_THREADS; t++) begin
            thread_cnt_r[t] <= '0;
         end
      end else if (clear) begin
         cycles_r        <= '0;
         total_r         <= '0;
         branches_r      <= '0;
         correct_r       <= '0;
         thread_halted_r <= '0;
         errored_r       <= 1'b0;
         idle_r          <= '0;
         for (int t = 0; t < NUM_THREADS; t++) begin
            thread_cnt_r[t] <= '0;
         end
      end else if (state_r == RUN) begin
         cycles_r        <= sat_add(cycles_r, INC_W'(1));
         total_r         <= sat_add(total_r, total_inc_s);
         branches_r      <= sat_add(branches_r, br_inc_s);
         correct_r       <= sat_add(correct_r, corr_inc_s);
         thread_halted_r <= thread_halted_r | halt_now_s;
         // Any RUN cycle with error_stop leaves RUN for DONE.
         errored_r       <= commit.error_stop;
         for (int t = 0; t < NUM_THREADS; t++) begin
            thread_cnt_r[t] <= sat_add(thread_cnt_r[t], thread_inc_s[t]);
         end
         if (activity_s) begin
            idle_r <= '0;
         end else if (idle_r != IDLE_LAST) begin
            idle_r <= idle_r + IDLE_W'(1);
         end else begin
            idle_r <= idle_r;
         end
      end else begin
         cycles_r <= cycles_r;
      end
   end

   // Thread-counter slice of the read mux.
   always_comb begin
      thread_pick_s = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         thread_pick_s = thread_pick_s |
                         ((rd_sel == SEL_W'(4 + t)) ? thread_cnt_r[t] : '0);
      end
   end

   // Read mux over registered counters, same-cycle response to rd_sel.
   always_comb begin
      rd_data = '0;
      case (rd_sel)
         SEL_W'(0): rd_data = cycles_r;
         SEL_W'(1): rd_data = total_r;
         SEL_W'(2): rd_data = branches_r;
         SEL_W'(3): rd_data = correct_r;
         default:   rd_data = thread_pick_s;
      endcase
   end

   assign state         = state_r;
   assign thread_halted = thread_halted_r;
   assign errored       = errored_r;

endmodule

// File: doc/commit_perf_monitor.md
Name: commit_perf_monitor

Overview:
Synthesizable, parametrised commit-stream monitor. Sits beside the ROBs of the SMT pipeline and counts cycles, committed instructions (per thread and total), branches and correctly predicted branches. Detects end of run when every active thread has committed a halt, or on a pipeline error. A no-commit watchdog flags hangs. Counters freeze at end of run and are read through a select/data port. This replaces testbench-only commit/CPI bookkeeping and generalises it to N threads × W commit lanes.

Parameters:
NUM_THREADS, 2, number of hardware threads (ROBs)
COMMIT_WIDTH, 2, commit lanes per thread per cycle; lane 0 is oldest
CNT_W, 32, width of every counter
TIMEOUT, 500000, consecutive cycles without a counted commit before hang; must be ≥1 and < 2^CNT_W
SEL_W, $clog2(4+NUM_THREADS), width of rd_sel

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous clear: counters and flags to 0, state to RUN
thread_active  in  NUM_THREADS  threads that must halt before done
commit_valid  in  NUM_THREADS*COMMIT_WIDTH  lane commits this cycle; index t*COMMIT_WIDTH+l
commit_halt  in  NUM_THREADS*COMMIT_WIDTH  committed lane is a halt
commit_branch  in  NUM_THREADS*COMMIT_WIDTH  committed lane is a branch
commit_br_correct  in  NUM_THREADS*COMMIT_WIDTH  branch was correctly predicted
error_stop  in  1  pipeline reported a non-halt error
rd_sel  in  SEL_W  0=cycles, 1=total instrs, 2=branches, 3=correct branches, 4+t=thread t instrs
rd_data  out  CNT_W  selected counter; 0 for out-of-range sel
state  out  2  0=RUN, 1=DONE, 2=HANG
thread_halted  out  NUM_THREADS  sticky per-thread halt seen
errored  out  1  DONE was entered through error_stop

Behaviour:
- Reset: all counters 0, thread_halted=0, errored=0, idle counter 0, state=RUN. rd_data reflects zeroed counters.
- clear has priority over all other updates in any state. reset overrides clear.
- Lane qualification per thread t: a lane is live if commit_valid is set and no lower-index lane of t has valid&halt in the same cycle. Lanes younger than a halt are ignored.
- A live halt lane sets thread_halted[t]. It is NOT counted as an instruction or branch.
- Counted lane: live, not halt, and thread_halted[t] not already set. Lanes of a thread that is already halted are ignored.
- Per-cycle increments are popcounts over counted lanes:
  - thread t counter += its counted lanes.
  - total += all counted lanes.
  - branches += counted lanes with commit_branch.
  - correct += counted lanes with commit_branch & commit_br_correct. commit_br_correct without commit_branch is ignored.
- All counters saturate at 2^CNT_W-1 and never wrap.
- RUN: cycles += 1 every cycle.
  - Idle counter resets to 0 on any counted commit or live halt; otherwise it increments.
- Transitions from RUN, next-state priority:
  1. error_stop → DONE, errored=1.
  2. thread_active nonzero, and every active thread's thread_halted (including halts this cycle) set → DONE.
  3. Idle counter reaches TIMEOUT-1 and no commit this cycle → HANG.
- The detecting cycle's commits and cycle increment are still applied. cycles therefore equals RUN cycles inclusive.
- thread_active=0 never completes by halt.
- DONE, HANG: all counters, thread_halted and errored are frozen. Inputs are ignored except clear. States are sticky until clear or reset.
- rd_data: combinational mux of registered counters; valid the same cycle rd_sel changes.

Test Plan:
- Reset, then 10 cycles with all lanes idle, TIMEOUT=1000 → cycles=10, total=0, state=RUN; rd_sel=7 → rd_data=0.
- T0 commits 2 lanes/cycle and T1 1 lane/cycle for 5 cycles → thread0=10, thread1=5, total=15, cycles=5.
- Same cycle, T0 lane0 halt + lane1 valid, T1 lane0 valid, thread_active=2'b11 → thread_halted=01, total+1, state RUN. Next cycle T1 lane1 halt → state DONE; further commits leave total unchanged.
- 4 branch commits, 3 with br_correct, plus 1 br_correct without branch → branches=4, correct=3.
- TIMEOUT=8, no commits after reset → state=HANG at the 8th edge, cycles=8. Pulse clear → all 0, RUN.
- CNT_W=4, 9 cycles × 2 commits on T0 → thread0 and total saturate at 15. error_stop → DONE, errored=1.
